// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_pkg
// Description : Shared TX state encoding and status-register constants.
// Revision    : 1.0
// ============================================================================
package console_pkg;

    typedef enum logic [2:0] {
        T_INIT = 3'd0,
        T_IDLE = 3'd1,
        T_SEND = 3'd2,
        T_WAIT = 3'd3,
        T_DONE = 3'd4
    } tx_state_t;

    localparam logic [15:0] DSR_READY    = 16'h8000;
    localparam logic [15:0] KBSR_READY   = 16'h8000;
    localparam logic [15:0] STATUS_CLEAR = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/console_io_if.sv
`default_nettype none
// ============================================================================
// Module      : console_io_if
// Description : Datapath/UART handshake bundle for the console controller.
// Revision    : 1.0
// ============================================================================
interface console_io_if;

    logic        ddr_wr;
    logic [7:0]  ddr;
    logic        kbdr_rd;
    logic        tx_done;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        rx_enable;
    logic        ld_dsr_ext;
    logic [15:0] dsr_ext;
    logic        ld_kbsr_ext;
    logic [15:0] kbsr_ext;
    logic        ld_kbdr_ext;
    logic [15:0] kbdr_ext;
    logic        tx_overrun;
    logic        rx_overrun;

    modport master (
        output ddr_wr, ddr, kbdr_rd, tx_done, rx_dv, rx_byte,
        input  tx_dv, tx_byte, rx_enable, ld_dsr_ext, dsr_ext, ld_kbsr_ext,
               kbsr_ext, ld_kbdr_ext, kbdr_ext, tx_overrun, rx_overrun
    );

    modport slave (
        input  ddr_wr, ddr, kbdr_rd, tx_done, rx_dv, rx_byte,
        output tx_dv, tx_byte, rx_enable, ld_dsr_ext, dsr_ext, ld_kbsr_ext,
               kbsr_ext, ld_kbdr_ext, kbdr_ext, tx_overrun, rx_overrun
    );

endinterface
`default_nettype wire

// File: rtl/console_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : console_rx_fifo
// Description : Small byte FIFO buffering received keystrokes.
// Revision    : 1.0
// ============================================================================
module console_rx_fifo #(
    parameter int RX_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          push,
    input  wire logic [7:0]                    din,
    input  wire logic                          pop,
    output logic      [7:0]                    dout,
    output logic                               empty,
    output logic                               full,
    output logic      [$clog2(RX_DEPTH):0]     count
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(RX_DEPTH);

    logic [7:0]    r_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/console_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : console_io_ctrl
// Description : LC-3 console controller: DSR/DDR display and KBSR/KBDR keyboard.
// Revision    : 1.0
// ============================================================================
module console_io_ctrl
    import console_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  wire logic       i_Clk,
    input  wire logic       reset_,
    console_io_if.slave     bus
);

    localparam int CW = $clog2(RX_DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(RX_DEPTH);

    tx_state_t     r_state;
    tx_state_t     w_next;
    logic [7:0]    r_tx_byte;
    logic          r_tx_ovr;
    logic          r_rx_ovr;
    logic          r_pres;
    logic          w_empty;
    logic          w_full;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic          w_init;
    logic          w_idle;
    logic          w_present;
    logic          w_pop;

    // Outputs are forced quiet while reset is held; T_INIT strobes appear on release.
    assign w_init    = (r_state == T_INIT) && !reset_;
    assign w_idle    = (r_state == T_IDLE);
    assign w_present = !reset_ && !w_empty && !r_pres;
    assign w_pop     = !reset_ && bus.kbdr_rd && r_pres;

    console_rx_fifo #(
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (i_Clk),
        .rst   (reset_),
        .push  (bus.rx_dv),
        .din   (bus.rx_byte),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    always_ff @(posedge i_Clk) begin
        if (reset_) r_state <= T_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            T_INIT:  w_next = T_IDLE;
            T_IDLE:  if (bus.ddr_wr) w_next = T_SEND;
            T_SEND:  w_next = T_WAIT;
            T_WAIT:  if (bus.tx_done) w_next = T_DONE;
            T_DONE:  w_next = T_IDLE;
            default: w_next = T_INIT;
        endcase
    end

    always_comb begin
        bus.tx_dv       = 1'b0;
        bus.ld_dsr_ext  = 1'b0;
        bus.dsr_ext     = STATUS_CLEAR;
        bus.ld_kbsr_ext = 1'b0;
        bus.kbsr_ext    = STATUS_CLEAR;
        bus.ld_kbdr_ext = 1'b0;
        bus.kbdr_ext    = 16'h0000;
        if (!reset_) begin
            bus.tx_dv       = (r_state == T_SEND);
            bus.ld_dsr_ext  = w_init || (r_state == T_SEND) || (r_state == T_DONE);
            bus.dsr_ext     = (w_init || (r_state == T_DONE)) ? DSR_READY : STATUS_CLEAR;
            bus.ld_kbsr_ext = w_init || w_present || w_pop;
            if (w_init)         bus.kbsr_ext = STATUS_CLEAR;
            else if (w_present) bus.kbsr_ext = KBSR_READY;
            bus.ld_kbdr_ext = w_present;
            if (w_present)      bus.kbdr_ext = {8'h00, w_head};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (reset_) begin
            r_tx_byte <= 8'h00;
            r_tx_ovr  <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_pres    <= 1'b0;
        end else begin
            r_tx_ovr <= bus.ddr_wr && !w_idle;
            r_rx_ovr <= bus.rx_dv && w_full && !w_pop;
            if (bus.ddr_wr && w_idle) r_tx_byte <= bus.ddr;
            if (w_pop)          r_pres <= 1'b0;
            else if (w_present) r_pres <= 1'b1;
        end
    end

    assign bus.tx_byte    = r_tx_byte;
    assign bus.rx_enable  = !reset_ && (w_count != c_depth);
    assign bus.tx_overrun = r_tx_ovr && !reset_;
    assign bus.rx_overrun = r_rx_ovr && !reset_;

endmodule
`default_nettype wire

// File: tb/tb_console_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_io_ctrl
// Description : Self-checking bench: queue-based console model plus directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_console_io_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    console_io_if bus ();

    console_io_ctrl #(
        .RX_DEPTH (D)
    ) dut (
        .i_Clk  (clk),
        .reset_ (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: received bytes in a queue, TX as scheduled event cycles.
    logic [7:0] q[$];
    bit         m_pres     = 1'b0;
    bit         m_prev_rst = 1'b1;
    bit         m_busy     = 1'b0;
    bit         m_txovr    = 1'b0;
    bit         m_rxovr    = 1'b0;
    int         send_at    = -1;
    int         done_at    = -1;
    logic [7:0] m_txb      = 8'h00;

    always @(negedge clk) begin : compare
        bit init, present, pop, idle, full;
        init    = m_prev_rst && !rst;
        present = !rst && (q.size() > 0) && !m_pres;
        pop     = !rst && bus.kbdr_rd && m_pres;

        chk("tx_dv",       16'(bus.tx_dv),       16'(!rst && cyc == send_at));
        chk("tx_byte",     16'(bus.tx_byte),     16'(m_txb));
        chk("ld_dsr_ext",  16'(bus.ld_dsr_ext),  16'(!rst && (init || cyc == send_at || cyc == done_at)));
        chk("dsr_ext",     bus.dsr_ext,          (!rst && (init || cyc == done_at)) ? 16'h8000 : 16'h0000);
        chk("ld_kbsr_ext", 16'(bus.ld_kbsr_ext), 16'(init || present || pop));
        chk("kbsr_ext",    bus.kbsr_ext,         (!init && present) ? 16'h8000 : 16'h0000);
        chk("ld_kbdr_ext", 16'(bus.ld_kbdr_ext), 16'(present));
        chk("kbdr_ext",    bus.kbdr_ext,         present ? {8'h00, q[0]} : 16'h0000);
        chk("rx_enable",   16'(bus.rx_enable),   16'(!rst && q.size() < D));
        chk("tx_overrun",  16'(bus.tx_overrun),  16'(!rst && m_txovr));
        chk("rx_overrun",  16'(bus.rx_overrun),  16'(!rst && m_rxovr));

        if (rst) begin
            q.delete();
            m_pres  = 1'b0;
            m_txovr = 1'b0;
            m_rxovr = 1'b0;
            m_busy  = 1'b0;
            send_at = -1;
            done_at = -1;
            m_txb   = 8'h00;
        end else begin
            idle    = !init && !m_busy;
            m_txovr = bus.ddr_wr && !idle;
            if (bus.ddr_wr && idle) begin
                m_txb   = bus.ddr;
                m_busy  = 1'b1;
                send_at = cyc + 1;
                done_at = -1;
            end else if (m_busy && cyc == done_at) begin
                m_busy = 1'b0;
            end else if (m_busy && cyc > send_at && done_at < 0 && bus.tx_done) begin
                done_at = cyc + 1;
            end
            full    = (q.size() == D);
            m_rxovr = bus.rx_dv && full && !pop;
            if (pop) begin
                void'(q.pop_front());
                m_pres = 1'b0;
            end else if (present) begin
                m_pres = 1'b1;
            end
            if (bus.rx_dv && (!full || pop)) q.push_back(bus.rx_byte);
        end
        m_prev_rst = rst;
        cyc++;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [7:0] drain_exp [3];
        drain_exp = '{8'h63, 8'h64, 8'h70};
        bus.ddr_wr  = 1'b0;
        bus.ddr     = 8'h00;
        bus.kbdr_rd = 1'b0;
        bus.tx_done = 1'b0;
        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;
        rst         = 1'b1;
        repeat (3) step();

        // Reset release: T_INIT strobes
        rst = 1'b0;
        @(negedge clk);
        chk("init ld_dsr", 16'(bus.ld_dsr_ext), 16'h0001);
        chk("init dsr", bus.dsr_ext, 16'h8000);
        chk("init ld_kbsr", 16'(bus.ld_kbsr_ext), 16'h0001);
        chk("init kbsr", bus.kbsr_ext, 16'h0000);
        chk("init rx_enable", 16'(bus.rx_enable), 16'h0001);

        // Single TX plus overrun while waiting
        step(); bus.ddr_wr = 1'b1; bus.ddr = 8'h41;
        step(); bus.ddr_wr = 1'b0;
        @(negedge clk);
        chk("tx start tx_dv", 16'(bus.tx_dv), 16'h0001);
        chk("tx start byte", 16'(bus.tx_byte), 16'h0041);
        chk("tx start dsr", bus.dsr_ext, 16'h0000);
        step(); bus.ddr_wr = 1'b1; bus.ddr = 8'h42;
        step(); bus.ddr_wr = 1'b0;
        @(negedge clk);
        chk("tx overrun pulse", 16'(bus.tx_overrun), 16'h0001);
        chk("tx overrun byte", 16'(bus.tx_byte), 16'h0041);
        chk("tx overrun no dv", 16'(bus.tx_dv), 16'h0000);
        repeat (8) step();
        bus.tx_done = 1'b1;
        step(); bus.tx_done = 1'b0;
        @(negedge clk);
        chk("tx done ld_dsr", 16'(bus.ld_dsr_ext), 16'h0001);
        chk("tx done dsr", bus.dsr_ext, 16'h8000);

        // RX fill to overflow
        for (int i = 0; i < 5; i++) begin
            step(); bus.rx_dv = 1'b1; bus.rx_byte = 8'h61 + 8'(i);
            if (i == 1) begin
                @(negedge clk);
                chk("rx first ld_kbdr", 16'(bus.ld_kbdr_ext), 16'h0001);
                chk("rx first kbdr", bus.kbdr_ext, 16'h0061);
                chk("rx first kbsr", bus.kbsr_ext, 16'h8000);
            end
            if (i == 4) begin
                @(negedge clk);
                chk("rx full rx_enable", 16'(bus.rx_enable), 16'h0000);
            end
        end
        step(); bus.rx_dv = 1'b0;
        @(negedge clk);
        chk("rx overrun pulse", 16'(bus.rx_overrun), 16'h0001);

        // Simultaneous push and pop while full
        step(); bus.rx_dv = 1'b1; bus.rx_byte = 8'h70; bus.kbdr_rd = 1'b1;
        @(negedge clk);
        chk("pop ld_kbsr", 16'(bus.ld_kbsr_ext), 16'h0001);
        chk("pop kbsr", bus.kbsr_ext, 16'h0000);
        step(); bus.rx_dv = 1'b0; bus.kbdr_rd = 1'b0;
        @(negedge clk);
        chk("pushpop no overrun", 16'(bus.rx_overrun), 16'h0000);
        chk("pushpop still full", 16'(bus.rx_enable), 16'h0000);
        chk("pushpop next kbdr", bus.kbdr_ext, 16'h0062);

        // Drain
        for (int i = 0; i < 3; i++) begin
            step(); bus.kbdr_rd = 1'b1;
            step(); bus.kbdr_rd = 1'b0;
            @(negedge clk);
            chk("drain ld_kbdr", 16'(bus.ld_kbdr_ext), 16'h0001);
            chk("drain kbdr", bus.kbdr_ext, {8'h00, drain_exp[i]});
            chk("drain kbsr", bus.kbsr_ext, 16'h8000);
        end
        step(); bus.kbdr_rd = 1'b1;
        step(); bus.kbdr_rd = 1'b0;
        @(negedge clk);
        chk("empty no ld_kbdr", 16'(bus.ld_kbdr_ext), 16'h0000);
        step(); bus.kbdr_rd = 1'b1;
        @(negedge clk);
        chk("idle read ignored", 16'(bus.ld_kbsr_ext), 16'h0000);
        step(); bus.kbdr_rd = 1'b0;

        // Reset during T_WAIT with two bytes buffered
        step(); bus.ddr_wr = 1'b1; bus.ddr = 8'h43; bus.rx_dv = 1'b1; bus.rx_byte = 8'h81;
        step(); bus.ddr_wr = 1'b0; bus.rx_byte = 8'h82;
        step(); bus.rx_dv = 1'b0;
        step(); rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reinit ld_dsr", 16'(bus.ld_dsr_ext), 16'h0001);
        chk("reinit dsr", bus.dsr_ext, 16'h8000);
        chk("reinit ld_kbsr", 16'(bus.ld_kbsr_ext), 16'h0001);
        chk("reinit ld_kbdr", 16'(bus.ld_kbdr_ext), 16'h0000);
        step();
        @(negedge clk);
        chk("flushed ld_kbdr", 16'(bus.ld_kbdr_ext), 16'h0000);
        chk("flushed rx_enable", 16'(bus.rx_enable), 16'h0001);
        chk("reset tx_byte", 16'(bus.tx_byte), 16'h0000);

        // TX after reset
        step(); bus.ddr_wr = 1'b1; bus.ddr = 8'h55;
        step(); bus.ddr_wr = 1'b0;
        repeat (3) step();
        bus.tx_done = 1'b1;
        step(); bus.tx_done = 1'b0;
        @(negedge clk);
        chk("post-reset done dsr", bus.dsr_ext, 16'h8000);
        chk("post-reset tx_byte", 16'(bus.tx_byte), 16'h0055);
        repeat (3) step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/console_io_ctrl.md
# console_io_ctrl

Memory-mapped console controller for the LC-3 top level. It sequences the display (DSR/DDR) and keyboard (KBSR/KBDR) handshakes between the datapath and the UART transmitter and receiver. Received bytes are buffered in a small FIFO so keystrokes are not lost while the program is busy. It drives the datapath's external status and data load ports.

## Interface
Parameters:
- RX_DEPTH, 4: RX FIFO entries; power of two, minimum 2.

Ports:
- i_Clk  in  1  system clock.
- reset_  in  1  synchronous, active-high reset.
- ddr_wr  in  1  one-cycle strobe: CPU wrote DDR (FSM LD_DDR).
- ddr  in  8  DDR[7:0], valid while ddr_wr is high.
- kbdr_rd  in  1  one-cycle strobe: CPU read KBDR.
- tx_done  in  1  UART TX byte complete (o_Tx_Done).
- rx_dv  in  1  UART RX byte valid (o_Rx_DV).
- rx_byte  in  8  received byte.
- tx_dv  out  1  one-cycle start pulse to UART TX.
- tx_byte  out  8  byte to transmit; held from tx_dv until tx_done.
- rx_enable  out  1  UART RX arm (i_Recieve); high while FIFO is not full.
- ld_dsr_ext  out  1  load strobe for DSR.
- dsr_ext  out  16  DSR value: 16'h8000 = ready, 16'h0000 = busy.
- ld_kbsr_ext  out  1  load strobe for KBSR.
- kbsr_ext  out  16  KBSR value: 16'h8000 = char available, 16'h0000 = none.
- ld_kbdr_ext  out  1  load strobe for KBDR.
- kbdr_ext  out  16  {8'h00, FIFO head}.
- tx_overrun  out  1  one-cycle pulse: ddr_wr arrived while TX was busy.
- rx_overrun  out  1  one-cycle pulse: rx_dv arrived while FIFO was full.

## Operation
- **TX FSM states:** T_INIT, T_IDLE, T_SEND, T_WAIT, T_DONE.
  - T_INIT: lasts one cycle after reset. Pulses ld_dsr_ext with 16'h8000 and ld_kbsr_ext with 16'h0000. Goes to T_IDLE.
  - T_IDLE, ddr_wr=1: latch ddr into tx_byte. Go to T_SEND.
  - T_SEND: tx_dv=1, ld_dsr_ext=1, dsr_ext=16'h0000. Go to T_WAIT.
  - T_WAIT: hold until tx_done=1, then go to T_DONE.
  - T_DONE: ld_dsr_ext=1, dsr_ext=16'h8000. Go to T_IDLE.
  - ddr_wr in any state other than T_IDLE: ignored, tx_overrun pulses the next cycle, tx_byte unchanged.
- **RX FIFO push:** rx_dv=1 with FIFO not full pushes rx_byte.
- **RX FIFO full:** rx_dv=1 with FIFO full drops the byte and pulses rx_overrun. rx_enable is low whenever count == RX_DEPTH.
- **Presentation flag `pres`:** when the FIFO is non-empty and pres=0, assert ld_kbdr_ext with the head byte and ld_kbsr_ext with 16'h8000 in the same cycle, then set pres.
- **Read:** kbdr_rd with pres=1 pops the head, clears pres, and pulses ld_kbsr_ext with 16'h0000. kbdr_rd with pres=0 is ignored.
- **Next byte:** after a pop, if the FIFO is still non-empty, the next byte is presented in the following cycle.
- **Simultaneous push and pop:** both take effect and count is unchanged. A push while the FIFO is full and a pop occur in the same cycle: the push is accepted.
- **Pointers:** log2(RX_DEPTH) bits, wrap naturally. count is log2(RX_DEPTH)+1 bits.
- **ld_kbsr_ext arbitration:** T_INIT has priority over the presentation and pop pulses. Presentation and pop never coincide, because pop requires pres=1 and presentation requires pres=0.

## Timing
- **Reset values:** all outputs 0; tx_byte 8'h00; FIFO empty; pres=0; TX state T_INIT.
  - rx_enable is 0 during reset and becomes 1 in T_INIT.
- **Reset mid-operation:** aborts any TX in progress and flushes the FIFO. Returns to T_INIT, so DSR and KBSR are re-synchronised on the first cycle after reset.
- **TX latency:** ddr_wr at cycle N → tx_dv and DSR busy at N+1. tx_done at cycle M → DSR ready strobe at M+1.
- **RX latency:** rx_dv at cycle N into an empty FIFO → ld_kbdr_ext/ld_kbsr_ext at N+1.
- **Read latency:** kbdr_rd at cycle N → KBSR clear strobe at N. If more data is buffered, the next presentation is at N+1.
- **Strobe width:** every ld_* pulse, tx_dv and each overrun pulse is exactly one cycle.

## Structure
- **Shared package console_pkg:** TX state enum; DSR_READY/KBSR_READY = 16'h8000; STATUS_CLEAR = 16'h0000.
- **Sub-module console_rx_fifo:** parameterised by RX_DEPTH.
  - Ports: push, din, pop, dout, empty, full, count.
  - The controller holds the TX FSM, the pres flag and the output muxing.

## Test plan
- **Reset release:** deassert reset_ → cycle 1 shows ld_dsr_ext=1 with 16'h8000 and ld_kbsr_ext=1 with 16'h0000; rx_enable=1.
- **Single TX:** ddr_wr with ddr=8'h41 → next cycle tx_dv=1, tx_byte=8'h41, dsr_ext=16'h0000. tx_done 10 cycles later → ld_dsr_ext with 16'h8000 one cycle after tx_done.
- **TX overrun:** a second ddr_wr=8'h42 while in T_WAIT → tx_overrun pulses, tx_byte stays 8'h41, no second tx_dv.
- **RX fill and drain:** push 8'h61..8'h65 with no reads, RX_DEPTH=4.
  - rx_enable falls after the 4th byte; the 5th byte raises rx_overrun.
  - The KBDR sequence over four kbdr_rd reads is 16'h0061..16'h0064, each followed by an ld_kbsr_ext strobe with 16'h8000.
- **Simultaneous push and pop:** FIFO full with pres=1; rx_dv=8'h70 and kbdr_rd in the same cycle → count stays 4, no rx_overrun, next KBDR = 16'h0062.
- **Reset mid-op:** reset_ asserted during T_WAIT with 2 bytes buffered → after release the FIFO is empty, no ld_kbdr_ext, and the T_INIT strobes repeat.
